// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock rdy/vld FIFO, any depth >= 2, with occupancy
//               count, almost-full flag, synchronous flush and an optional
//               empty-FIFO bypass enabled by defining SYNC_FIFO_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         rst_bar,
    input  logic                         flush,
    input  logic                         in1_vld,
    output logic                         in1_rdy,
    input  logic [WIDTH-1:0]             in1_dat,
    output logic                         out1_vld,
    input  logic                         out1_rdy,
    output logic [WIDTH-1:0]             out1_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         afull
);

    localparam int c_cw = $clog2(DEPTH + 1);
    localparam int c_pw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [c_pw-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_pw-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cw-1:0] count_q,  count_d;
    logic            rst_done_q, rst_done_d;

    logic w_full;
    logic w_empty;
    logic w_bypass_take;
    logic w_push;
    logic w_pop;

    always_comb begin
        w_full  = (count_q == c_cw'(DEPTH));
        w_empty = (count_q == '0);
        in1_rdy = rst_done_q & ~w_full & ~flush;
`ifdef SYNC_FIFO_BYPASS_EN
        // When empty, the producer's word is presented straight to the consumer.
        if (w_empty & ~flush & rst_done_q) begin
            out1_vld      = in1_vld;
            out1_dat      = in1_dat;
            w_bypass_take = in1_vld & out1_rdy;
        end else begin
            out1_vld      = ~w_empty & ~flush;
            out1_dat      = mem_q[rd_ptr_q];
            w_bypass_take = 1'b0;
        end
`else
        out1_vld      = ~w_empty & ~flush;
        out1_dat      = mem_q[rd_ptr_q];
        w_bypass_take = 1'b0;
`endif
        w_push = in1_vld & in1_rdy & ~w_bypass_take;
        w_pop  = out1_vld & out1_rdy & ~w_bypass_take;
        afull  = (count_q >= c_cw'(AFULL_THRESH));
        count  = count_q;
    end

    always_comb begin
        rst_done_d = 1'b1;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = (wr_ptr_q == c_pw'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_d = (rd_ptr_q == c_pw'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (w_push && !w_pop) begin
                count_d = count_q + 1'b1;
            end else if (w_pop && !w_push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            rst_done_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            rst_done_q <= rst_done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage is not reset or flushed; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= in1_dat;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo
// Description : Directed vector table plus hand-written sequences for
//               sync_fifo at WIDTH=8, DEPTH=5.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

`ifdef SYNC_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk;
    logic       rst_bar;
    logic       flush;
    logic       in1_vld;
    logic       in1_rdy;
    logic [7:0] in1_dat;
    logic       out1_vld;
    logic       out1_rdy;
    logic [7:0] out1_dat;
    logic [2:0] count;
    logic       afull;

    int total;
    int bad;

    sync_fifo #(.WIDTH(8), .DEPTH(5)) dut (
        .clk      (clk),
        .rst_bar  (rst_bar),
        .flush    (flush),
        .in1_vld  (in1_vld),
        .in1_rdy  (in1_rdy),
        .in1_dat  (in1_dat),
        .out1_vld (out1_vld),
        .out1_rdy (out1_rdy),
        .out1_dat (out1_dat),
        .count    (count),
        .afull    (afull)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit       f;
        bit       vld;
        bit [7:0] dat;
        bit       rdy;
        bit       e_irdy;
        bit       e_ovld;
        bit       chk_dat;
        bit [7:0] e_dat;
        int       e_cnt;
        bit       e_af;
    } vec_t;

    vec_t vecs [23];

    function automatic vec_t mk(bit f, bit vld, bit [7:0] dat, bit rdy, bit e_irdy,
                                bit e_ovld, bit chk_dat, bit [7:0] e_dat, int e_cnt, bit e_af);
        vec_t v;
        v.f = f; v.vld = vld; v.dat = dat; v.rdy = rdy;
        v.e_irdy = e_irdy; v.e_ovld = e_ovld; v.chk_dat = chk_dat;
        v.e_dat = e_dat; v.e_cnt = e_cnt; v.e_af = e_af;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        bit [7:0] q [$];
        int       mcount;
        int       sent;
        int       rcvd;
        bit       e_ovld;
        bit       byp_take;
        bit       do_push;
        bit       do_pop;

        total = 0;
        bad   = 0;

        //            f  vld dat    rdy irdy ovld      chk       dat    cnt af
        vecs[0]  = mk(0, 1, 8'h11, 0,  1,   BYP,      BYP,      8'h11, 0, 0);
        vecs[1]  = mk(0, 1, 8'h12, 0,  1,   1,        1,        8'h11, 1, 0);
        vecs[2]  = mk(0, 1, 8'h13, 0,  1,   1,        1,        8'h11, 2, 0);
        vecs[3]  = mk(0, 1, 8'h14, 0,  1,   1,        1,        8'h11, 3, 0);
        vecs[4]  = mk(0, 1, 8'h15, 0,  1,   1,        1,        8'h11, 4, 1);
        vecs[5]  = mk(0, 1, 8'h16, 0,  0,   1,        1,        8'h11, 5, 1);
        vecs[6]  = mk(0, 1, 8'h16, 1,  0,   1,        1,        8'h11, 5, 1);
        vecs[7]  = mk(0, 1, 8'h16, 0,  1,   1,        1,        8'h12, 4, 1);
        vecs[8]  = mk(0, 0, 8'h00, 1,  0,   1,        1,        8'h12, 5, 1);
        vecs[9]  = mk(0, 0, 8'h00, 1,  1,   1,        1,        8'h13, 4, 1);
        vecs[10] = mk(0, 0, 8'h00, 1,  1,   1,        1,        8'h14, 3, 0);
        vecs[11] = mk(0, 0, 8'h00, 1,  1,   1,        1,        8'h15, 2, 0);
        vecs[12] = mk(0, 0, 8'h00, 1,  1,   1,        1,        8'h16, 1, 0);
        vecs[13] = mk(0, 0, 8'h00, 0,  1,   0,        0,        8'h00, 0, 0);
        vecs[14] = mk(0, 1, 8'hA1, 0,  1,   BYP,      BYP,      8'hA1, 0, 0);
        vecs[15] = mk(0, 1, 8'hA2, 0,  1,   1,        1,        8'hA1, 1, 0);
        vecs[16] = mk(0, 1, 8'hA3, 0,  1,   1,        1,        8'hA1, 2, 0);
        vecs[17] = mk(1, 1, 8'hA4, 1,  0,   0,        0,        8'h00, 3, 0);
        vecs[18] = mk(0, 0, 8'h00, 0,  1,   0,        0,        8'h00, 0, 0);
        vecs[19] = mk(0, 1, 8'hA5, 1,  1,   BYP,      BYP,      8'hA5, 0, 0);
        vecs[20] = mk(0, 0, 8'h00, 0,  1,   !BYP,     !BYP,     8'hA5, BYP ? 0 : 1, 0);
        vecs[21] = mk(0, 0, 8'h00, 1,  1,   !BYP,     !BYP,     8'hA5, BYP ? 0 : 1, 0);
        vecs[22] = mk(0, 0, 8'h00, 0,  1,   0,        0,        8'h00, 0, 0);

        // Reset held for three cycles, then released.
        rst_bar  = 1'b0;
        flush    = 1'b0;
        in1_vld  = 1'b0;
        in1_dat  = 8'h00;
        out1_rdy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_in1_rdy", int'(in1_rdy), 0);
            check("rst_out1_vld", int'(out1_vld), 0);
            check("rst_count", int'(count), 0);
            check("rst_afull", int'(afull), 0);
        end
        @(posedge clk);
        #1 rst_bar = 1'b1;
        @(negedge clk);
        check("rel_cycle1_in1_rdy", int'(in1_rdy), 0);
        @(negedge clk);
        check("rel_cycle2_in1_rdy", int'(in1_rdy), 1);
        check("rel_cycle2_count", int'(count), 0);
        check("rel_cycle2_out1_vld", int'(out1_vld), 0);

        for (int i = 0; i < 23; i++) begin
            @(posedge clk);
            #1;
            flush    = vecs[i].f;
            in1_vld  = vecs[i].vld;
            in1_dat  = vecs[i].dat;
            out1_rdy = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("v%0d_in1_rdy", i), int'(in1_rdy), int'(vecs[i].e_irdy));
            check($sformatf("v%0d_out1_vld", i), int'(out1_vld), int'(vecs[i].e_ovld));
            check($sformatf("v%0d_count", i), int'(count), vecs[i].e_cnt);
            check($sformatf("v%0d_afull", i), int'(afull), int'(vecs[i].e_af));
            if (vecs[i].chk_dat) begin
                check($sformatf("v%0d_out1_dat", i), int'(out1_dat), int'(vecs[i].e_dat));
            end
        end

        // Randomly stalled stream of 23 words against a queue model.
        mcount = 0;
        sent   = 0;
        rcvd   = 0;
        for (int cyc = 0; cyc < 500 && rcvd < 23; cyc++) begin
            @(posedge clk);
            #1;
            flush    = 1'b0;
            in1_vld  = (sent < 23) && ($urandom_range(0, 3) != 0);
            in1_dat  = 8'($urandom_range(0, 255));
            out1_rdy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            e_ovld   = (mcount != 0) || (BYP && in1_vld);
            byp_take = BYP && (mcount == 0) && in1_vld && out1_rdy;
            check("st_count", int'(count), mcount);
            check("st_in1_rdy", int'(in1_rdy), int'(mcount != 5));
            check("st_out1_vld", int'(out1_vld), int'(e_ovld));
            do_push = in1_vld && (mcount != 5) && !byp_take;
            do_pop  = e_ovld && out1_rdy && !byp_take;
            if (byp_take) begin
                check("st_byp_dat", int'(out1_dat), int'(in1_dat));
                sent++;
                rcvd++;
            end
            if (do_pop) begin
                check("st_out1_dat", int'(out1_dat), int'(q[0]));
                void'(q.pop_front());
                rcvd++;
            end
            if (do_push) begin
                q.push_back(in1_dat);
                sent++;
            end
            mcount = mcount + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
        end
        check("st_words_received", rcvd, 23);

        // Asynchronous reset in the middle of operation.
        @(posedge clk);
        #1;
        in1_vld  = 1'b1;
        in1_dat  = 8'h5A;
        out1_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 in1_vld = 1'b0;
        @(negedge clk);
        check("mid_pre_count", int'(count), mcount + 2);
        #2 rst_bar = 1'b0;
        #1;
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_out1_vld", int'(out1_vld), 0);
        check("mid_rst_in1_rdy", int'(in1_rdy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
